// File: rtl/mux_8_1.sv
// Eight-input selector: a zero-latency combinational output Z plus a registered
// copy Z_q, and sel_q records which select value produced that copy.
module mux_8_1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             S2,
  input  logic             S1,
  input  logic             S0,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] E,
  input  logic [WIDTH-1:0] F,
  input  logic [WIDTH-1:0] G,
  input  logic [WIDTH-1:0] H,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] Z_q,
  output logic [2:0]       sel_q
);

  logic [2:0] sel;

  assign sel = {S2, S1, S0};

  // An unknown select falls into the default branch, so Z goes to all-zeros.
  always_comb begin
    Z = '0;
    case (sel)
      3'b000:  Z = A;
      3'b001:  Z = B;
      3'b010:  Z = C;
      3'b011:  Z = D;
      3'b100:  Z = E;
      3'b101:  Z = F;
      3'b110:  Z = G;
      3'b111:  Z = H;
      default: Z = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Z_q   <= '0;
      sel_q <= 3'b000;
    end else if (en) begin
      Z_q   <= Z;
      sel_q <= sel;
    end
  end

endmodule

// File: tb/tb_mux_8_1.sv
// Scoreboard bench for mux_8_1: a WIDTH=1 and a WIDTH=8 instance share the
// select, clock, reset and enable so both data widths are exercised together.
module tb_mux_8_1;

  typedef struct {
    logic [2:0] sel;
    logic [0:0] zq1;
    logic [7:0] zq8;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       S2, S1, S0;
  logic [0:0] d1 [8];
  logic [7:0] d8 [8];
  logic [0:0] z1, zq1;
  logic [7:0] z8, zq8;
  logic [2:0] selq1, selq8;

  exp_t       sb_q[$];
  exp_t       model;
  int         errors;
  int         checks;

  mux_8_1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .S2(S2), .S1(S1), .S0(S0),
    .A(d1[0]), .B(d1[1]), .C(d1[2]), .D(d1[3]),
    .E(d1[4]), .F(d1[5]), .G(d1[6]), .H(d1[7]),
    .Z(z1), .Z_q(zq1), .sel_q(selq1)
  );

  mux_8_1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .S2(S2), .S1(S1), .S0(S0),
    .A(d8[0]), .B(d8[1]), .C(d8[2]), .D(d8[3]),
    .E(d8[4]), .F(d8[5]), .G(d8[6]), .H(d8[7]),
    .Z(z8), .Z_q(zq8), .sel_q(selq8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of stimulus from a falling edge, check Z and the still-held
  // registers before the rising edge, then check the captured registers after it.
  task automatic applyStimulus(input logic [2:0] s, input logic r, input logic e,
                               input string tag);
    exp_t nxt;
    exp_t got;
    {S2, S1, S0} = s;
    rst_n = r;
    en = e;
    #1;
    checkOutput({tag, "_z1"}, 32'(z1), 32'(d1[s]));
    checkOutput({tag, "_z8"}, 32'(z8), 32'(d8[s]));
    checkOutput({tag, "_pre_zq8"}, 32'(zq8), 32'(model.zq8));
    checkOutput({tag, "_pre_selq"}, 32'(selq8), 32'(model.sel));
    nxt = model;
    if (!r) begin
      nxt.sel = 3'b000;
      nxt.zq1 = 1'b0;
      nxt.zq8 = 8'h00;
    end else if (e) begin
      nxt.sel = s;
      nxt.zq1 = d1[s];
      nxt.zq8 = d8[s];
    end
    sb_q.push_back(nxt);
    model = nxt;
    @(posedge clk);
    @(negedge clk);
    got = sb_q.pop_front();
    checkOutput({tag, "_zq1"}, 32'(zq1), 32'(got.zq1));
    checkOutput({tag, "_zq8"}, 32'(zq8), 32'(got.zq8));
    checkOutput({tag, "_selq1"}, 32'(selq1), 32'(got.sel));
    checkOutput({tag, "_selq8"}, 32'(selq8), 32'(got.sel));
  endtask

  task automatic clearData(input logic [0:0] v1, input logic [7:0] v8);
    for (int i = 0; i < 8; i++) begin
      d1[i] = v1;
      d8[i] = v8;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    en = 1'b0;
    {S2, S1, S0} = 3'b000;
    clearData(1'b0, 8'h00);
    model.sel = 3'b000;
    model.zq1 = 1'b0;
    model.zq8 = 8'h00;

    // Two reset edges bring the registers out of their power-up state.
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(3'd3, 1'b0, 1'b1, "reset");

    // One-hot walk: only the selected input is high.
    for (int s = 0; s < 8; s++) begin
      clearData(1'b0, 8'h00);
      d1[s] = 1'b1;
      d8[s] = 8'h01 << s;
      applyStimulus(3'(s), 1'b1, 1'b1, $sformatf("onehot%0d", s));
    end

    // Inverse walk: the selected input is low, every other input is high.
    for (int s = 0; s < 8; s++) begin
      clearData(1'b1, 8'hFF);
      d1[s] = 1'b0;
      d8[s] = 8'h00;
      applyStimulus(3'(s), 1'b1, 1'b1, $sformatf("inverse%0d", s));
    end

    // Registered path: sel=5 with F=1, then sel=0 with A=0.
    clearData(1'b0, 8'h00);
    d1[5] = 1'b1;
    d8[5] = 8'h5A;
    applyStimulus(3'd5, 1'b1, 1'b1, "reg_f");
    applyStimulus(3'd0, 1'b1, 1'b1, "reg_a");

    // Hold: load from H, then disable and switch to A=0 for three edges.
    clearData(1'b0, 8'h00);
    d1[7] = 1'b1;
    d8[7] = 8'hC3;
    applyStimulus(3'd7, 1'b1, 1'b1, "hold_load");
    for (int k = 0; k < 3; k++)
      applyStimulus(3'd0, 1'b1, 1'b0, $sformatf("hold%0d", k));

    // Synchronous reset mid-operation, with en still high.
    clearData(1'b0, 8'h00);
    d1[6] = 1'b1;
    d8[6] = 8'h96;
    applyStimulus(3'd6, 1'b1, 1'b1, "rst_load");
    applyStimulus(3'd6, 1'b0, 1'b1, "rst_sync");
    applyStimulus(3'd6, 1'b1, 1'b1, "rst_release");

    // Byte sweep with distinct patterns on every input.
    for (int i = 0; i < 8; i++) begin
      d8[i] = 8'(8'h11 * (i + 1));
      d1[i] = 1'(i % 2);
    end
    for (int s = 0; s < 8; s++)
      applyStimulus(3'(s), 1'b1, 1'b1, $sformatf("sweep%0d", s));

    // Random traffic with occasional hold and reset cycles.
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 8; i++) begin
        d8[i] = 8'($urandom);
        d1[i] = 1'($urandom);
      end
      applyStimulus(3'($urandom_range(0, 7)), 1'($urandom_range(0, 7) != 0),
                    1'($urandom_range(0, 3) != 0), $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
